// File: rtl/chu_vga_line_capture_core.sv
// chu_vga_line_capture_core
// Video-slot core that copies one horizontal run of up to 2**ADDR_WIDTH pixels
// from the blended pixel stream into a capture RAM that the processor reads
// over the slot bus. The capture starts at (x0,y0) of the next whole frame.
// The stream itself passes through with zero latency.
// Build option: define CAPTURE_MARKER_EN to overlay MARKER_RGB on the span
// being captured while the core is busy and MARK is set.

module chu_vga_line_capture_core #(
    parameter int            CD         = 12,
    parameter int            ADDR_WIDTH = 10,
    parameter int            HRES       = 640,
    parameter logic [CD-1:0] MARKER_RGB = 12'hF0F
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    // count/len need one extra bit so a full RAM (2**ADDR_WIDTH) is representable
    localparam int CW    = ADDR_WIDTH + 1;
    // width wide enough for x0 + count without overflow
    localparam int SW    = ((CW > 11) ? CW : 11) + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [CW-1:0] LEN_ONE   = CW'(1);
    localparam logic [CW-1:0] LEN_MAX   = CW'(DEPTH);
    localparam logic [31:0]   LEN_MAX_W = 32'(DEPTH);
    localparam logic [SW-1:0] HRES_W    = SW'(HRES);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_X0     = 3'd1;
    localparam logic [2:0] REG_Y0     = 3'd2;
    localparam logic [2:0] REG_LEN    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAITF = 2'd1,
        ST_SEEK  = 2'd2,
        ST_CAP   = 2'd3
    } state_t;

    // LEN write: zero becomes one, anything beyond the RAM depth saturates
    function automatic logic [CW-1:0] clamp_len(input logic [31:0] v);
        logic [CW-1:0] r;
        if (v == 32'd0) begin
            r = LEN_ONE;
        end else if (v > LEN_MAX_W) begin
            r = LEN_MAX;
        end else begin
            r = v[CW-1:0];
        end
        return r;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;

    logic [10:0]     x0_r;
    logic [10:0]     y0_r;
    logic [CW-1:0]   len_r;

    // working copies latched at ARM so bus writes during a capture do not disturb it
    logic [10:0]     x0_cap_r;
    logic [10:0]     y0_cap_r;
    logic [CW-1:0]   len_cap_r;

    logic [CW-1:0]   count_r;
    logic            done_r;
    logic            trunc_r;
    logic [31:0]     rd_data_r;

    logic [CD-1:0]   ram_r [DEPTH];

    logic            bus_wr_s;
    logic            bus_rd_s;
    logic            reg_wr_s;
    logic            ctrl_wr_s;
    logic            arm_s;
    logic            abort_s;

    logic            frame_start_s;
    logic            seek_hit_s;
    logic [SW-1:0]   sum_s;
    logic            cap_hit_s;
    logic            cap_full_s;
    logic            cap_edge_s;
    logic            cap_line_s;
    logic            cap_exit_s;

    logic            busy_s;
    logic            arm_go_s;
    logic            store_s;
    logic [ADDR_WIDTH-1:0] store_addr_s;
    logic            done_set_s;
    logic            trunc_set_s;

    logic [31:0]     reg_rd_s;
    logic [31:0]     ram_word_s;
    logic            unused_s;

    // ---------------- bus decode ----------------
    assign bus_wr_s  = cs & write;
    assign bus_rd_s  = cs & read;
    assign reg_wr_s  = bus_wr_s & addr[13];
    assign ctrl_wr_s = reg_wr_s & (addr[2:0] == REG_CTRL);
    // ABORT has priority: an ARM in the same write is discarded
    assign abort_s   = ctrl_wr_s & wr_data[1];
    assign arm_s     = ctrl_wr_s & wr_data[0] & ~wr_data[1];

    // ---------------- capture conditions ----------------
    assign frame_start_s = (x == 11'd0) && (y == 11'd0);
    assign seek_hit_s    = (x == x0_cap_r) && (y == y0_cap_r);
    assign sum_s         = SW'(x0_cap_r) + SW'(count_r);
    // match on the exact next column so a repeated (x,y) is never stored twice
    assign cap_hit_s     = (SW'(x) == sum_s);
    assign cap_full_s    = (count_r == len_cap_r);
    assign cap_edge_s    = (sum_s >= HRES_W);
    assign cap_line_s    = (y != y0_cap_r);
    assign cap_exit_s    = cap_full_s | cap_edge_s | cap_line_s;

    // Bus-visible configuration registers X0, Y0, LEN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_r  <= 11'd0;
            y0_r  <= 11'd0;
            len_r <= LEN_ONE;
        end else if (reg_wr_s) begin
            case (addr[2:0])
                REG_X0:  x0_r  <= wr_data[10:0];
                REG_Y0:  y0_r  <= wr_data[10:0];
                REG_LEN: len_r <= clamp_len(wr_data);
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; ABORT returns to IDLE from anywhere
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm_s) begin
                        state_nxt_s = ST_WAITF;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAITF: begin
                    if (frame_start_s) begin
                        state_nxt_s = ST_SEEK;
                    end else begin
                        state_nxt_s = ST_WAITF;
                    end
                end
                ST_SEEK: begin
                    if (seek_hit_s) begin
                        state_nxt_s = ST_CAP;
                    end else begin
                        state_nxt_s = ST_SEEK;
                    end
                end
                ST_CAP: begin
                    // leaving CAP is the DONE transition: straight back to IDLE
                    if (cap_exit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CAP;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag, RAM store strobe/address, completion flags
    always_comb begin
        busy_s       = 1'b0;
        arm_go_s     = 1'b0;
        store_s      = 1'b0;
        store_addr_s = count_r[ADDR_WIDTH-1:0];
        done_set_s   = 1'b0;
        trunc_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arm_go_s = arm_s;
            end
            ST_WAITF: begin
                busy_s = 1'b1;
            end
            ST_SEEK: begin
                busy_s       = 1'b1;
                store_s      = seek_hit_s & ~abort_s;
                store_addr_s = {ADDR_WIDTH{1'b0}};
            end
            ST_CAP: begin
                busy_s = 1'b1;
                if (cap_exit_s) begin
                    done_set_s  = ~abort_s;
                    // a full run is a clean finish; line edge or line change is a truncation
                    trunc_set_s = ~cap_full_s;
                end else begin
                    store_s = cap_hit_s & ~abort_s;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Capture engine datapath: latched config, pixel count and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_cap_r  <= 11'd0;
            y0_cap_r  <= 11'd0;
            len_cap_r <= LEN_ONE;
            count_r   <= {CW{1'b0}};
            done_r    <= 1'b0;
            trunc_r   <= 1'b0;
        end else if (abort_s) begin
            done_r <= 1'b0;
        end else if (arm_go_s) begin
            x0_cap_r  <= x0_r;
            y0_cap_r  <= y0_r;
            len_cap_r <= len_r;
            count_r   <= {CW{1'b0}};
            done_r    <= 1'b0;
            trunc_r   <= 1'b0;
        end else if (store_s) begin
            count_r <= CW'(store_addr_s) + LEN_ONE;
        end else if (done_set_s) begin
            done_r  <= 1'b1;
            trunc_r <= trunc_set_s;
        end
    end

    // Capture RAM write port; only the engine writes it, contents survive ABORT
    always_ff @(posedge clk) begin
        if (store_s) begin
            ram_r[store_addr_s] <= si_rgb;
        end
    end

    assign ram_word_s = 32'(ram_r[addr[ADDR_WIDTH-1:0]]);

    // Register read mux; unmapped offsets and write-only CTRL read as zero
    always_comb begin
        reg_rd_s = 32'd0;
        case (addr[2:0])
            REG_X0:     reg_rd_s = {21'd0, x0_r};
            REG_Y0:     reg_rd_s = {21'd0, y0_r};
            REG_LEN:    reg_rd_s = 32'(len_r);
            REG_STATUS: reg_rd_s = {18'd0, trunc_r, 11'(count_r), done_r, busy_s};
            default:    reg_rd_s = 32'd0;
        endcase
    end

    // Registered read data, updated only on a read so it holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= 32'd0;
        end else if (bus_rd_s) begin
            rd_data_r <= addr[13] ? reg_rd_s : ram_word_s;
        end
    end

    assign rd_data = rd_data_r;

`ifdef CAPTURE_MARKER_EN
    logic mark_r;
    logic mark_hit_s;

    // MARK flag follows CTRL bit2 on every CTRL write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mark_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            mark_r <= wr_data[2];
        end
    end

    // marker span uses the latched copies so it tracks the capture in flight
    assign mark_hit_s = mark_r & busy_s & (y == y0_cap_r) & (x >= x0_cap_r) &
                        (SW'(x) < (SW'(x0_cap_r) + SW'(len_cap_r)));
    assign so_rgb     = mark_hit_s ? MARKER_RGB : si_rgb;
    assign unused_s   = ^addr[12:0];
`else
    assign so_rgb   = si_rgb;
    assign unused_s = ^{addr[12:0], MARKER_RGB};
`endif

endmodule

// File: tb/tb_chu_vga_line_capture_core.sv
// Self-checking bench for chu_vga_line_capture_core. The bench drives the pixel
// position directly (frame start, then the capture line) and keeps expected
// read values in a scoreboard queue that is drained by bus reads.

module tb_chu_vga_line_capture_core;

    localparam logic [13:0] R_CTRL   = 14'h2000;
    localparam logic [13:0] R_X0     = 14'h2001;
    localparam logic [13:0] R_Y0     = 14'h2002;
    localparam logic [13:0] R_LEN    = 14'h2003;
    localparam logic [13:0] R_STATUS = 14'h2004;
    localparam logic [13:0] R_BAD    = 14'h2005;

    logic        clk;
    logic        reset_n;
    logic [10:0] x;
    logic [10:0] y;
    logic        cs;
    logic        write;
    logic        read;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [11:0] si_rgb;
    logic [11:0] so_rgb;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [13:0] adr_q[$];

    chu_vga_line_capture_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y),
        .cs      (cs),
        .write   (write),
        .read    (read),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .si_rgb  (si_rgb),
        .so_rgb  (so_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic b, input logic d, input int c, input logic t);
        return {18'd0, t, 11'(c), d, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        x      = 11'd799;
        y      = 11'd400;
        si_rgb = 12'd0;
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [13:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        tick();
        cs = 1'b0; read = 1'b0;
        d = rd_data;
    endtask

    task automatic frame_start();
        x = 11'd0; y = 11'd0; si_rgb = 12'd0;
        tick();
        park();
    endtask

    task automatic drive_line(input int yy, input logic [11:0] tag, input int reps);
        for (int xx = 0; xx < 800; xx++) begin
            x = 11'(xx); y = 11'(yy); si_rgb = 12'(xx) + tag;
            repeat (reps) tick();
        end
        park();
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        logic [13:0] a;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd_data got=%h expected=%h", rd_data, 32'd0);
        end
        reset_n = 1'b1;
        tick();
        adr_q.push_back(R_X0);     exp_q.push_back(32'd0);
        adr_q.push_back(R_Y0);     exp_q.push_back(32'd0);
        adr_q.push_back(R_LEN);    exp_q.push_back(32'd1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b0, 0, 1'b0));
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_regs addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] got, exp;
        logic [31:0] lenv [4] = '{32'd0, 32'd5000, 32'd1024, 32'd77};
        logic [31:0] lene [4] = '{32'd1, 32'd1024, 32'd1024, 32'd77};
        for (int i = 0; i < 4; i++) begin
            bus_wr(R_LEN, lenv[i]);
            exp_q.push_back(lene[i]);
            bus_rd(R_LEN, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL len_clamp wrote=%0d got=%0d expected=%0d", lenv[i], got, exp);
            end
        end
        repeat (3) tick();
        checks++;
        if (rd_data !== 32'd77) begin
            errors++;
            $display("FAIL rd_data_hold got=%h expected=%h", rd_data, 32'd77);
        end
        bus_wr(R_X0, 32'hFFFF_F7FF);
        bus_wr(R_Y0, 32'd9);
        bus_wr(R_BAD, 32'hFFFF_FFFF);
        adr_q.push_back(R_X0);   exp_q.push_back(32'h7FF);
        adr_q.push_back(R_Y0);   exp_q.push_back(32'd9);
        adr_q.push_back(R_BAD);  exp_q.push_back(32'd0);
        adr_q.push_back(R_CTRL); exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            logic [13:0] a;
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL regs_rw addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_capture_basic();
        logic [31:0] got, exp;
        logic [13:0] a;
        bus_wr(R_X0, 32'd100); bus_wr(R_Y0, 32'd50); bus_wr(R_LEN, 32'd4);
        bus_wr(R_CTRL, 32'd1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b1, 1'b0, 0, 1'b0));
        a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_busy got=%h expected=%h", got, exp);
        end
        frame_start();
        // every pixel held two cycles: each column must still be stored once
        drive_line(50, 12'd0, 2);
        bus_wr(14'h0000, 32'h0000_0ABC);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 4, 1'b0));
        for (int i = 0; i < 4; i++) begin
            adr_q.push_back(14'(i)); exp_q.push_back(32'(100 + i));
        end
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_capture addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] got, exp;
        logic [13:0] a;
        // run reaches the right edge of the active line
        bus_wr(R_X0, 32'd638); bus_wr(R_LEN, 32'd8); bus_wr(R_CTRL, 32'd1);
        frame_start();
        drive_line(50, 12'd0, 1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 2, 1'b1));
        adr_q.push_back(14'd0);    exp_q.push_back(32'd638);
        adr_q.push_back(14'd1);    exp_q.push_back(32'd639);
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL edge_trunc addr=%h got=%h expected=%h", a, got, exp);
            end
        end
        // start column already beyond the active line
        bus_wr(R_X0, 32'd700); bus_wr(R_LEN, 32'd4); bus_wr(R_CTRL, 32'd1);
        frame_start();
        drive_line(50, 12'd0, 1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 1, 1'b1));
        adr_q.push_back(14'd0);    exp_q.push_back(32'd700);
        // line changes before the run completes
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL x0_beyond addr=%h got=%h expected=%h", a, got, exp);
            end
        end
        bus_wr(R_X0, 32'd3); bus_wr(R_LEN, 32'd8); bus_wr(R_CTRL, 32'd1);
        frame_start();
        for (int xx = 0; xx < 6; xx++) begin
            x = 11'(xx); y = 11'd50; si_rgb = 12'(xx + 7);
            tick();
        end
        x = 11'd6; y = 11'd51; si_rgb = 12'd13;
        tick();
        park();
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 3, 1'b1));
        for (int i = 0; i < 3; i++) begin
            adr_q.push_back(14'(i)); exp_q.push_back(32'(10 + i));
        end
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL line_end_trunc addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_mid_frame_arm();
        logic [31:0] got, exp;
        logic [13:0] a;
        bus_wr(R_X0, 32'd200); bus_wr(R_Y0, 32'd50); bus_wr(R_LEN, 32'd4);
        x = 11'd300; y = 11'd200;
        bus_wr(R_CTRL, 32'd1);
        // rest of this frame must not be captured
        drive_line(50, 12'h100, 1);
        bus_wr(R_X0, 32'd300);
        bus_wr(R_CTRL, 32'd1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b1, 1'b0, 0, 1'b0));
        adr_q.push_back(14'd0);    exp_q.push_back(32'd10);
        adr_q.push_back(R_X0);     exp_q.push_back(32'd300);
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midframe_wait addr=%h got=%h expected=%h", a, got, exp);
            end
        end
        frame_start();
        drive_line(50, 12'h200, 1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 4, 1'b0));
        for (int i = 0; i < 4; i++) begin
            adr_q.push_back(14'(i)); exp_q.push_back(32'(200 + 12'h200 + i));
        end
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midframe_capture addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] got, exp;
        logic [13:0] a;
        bus_wr(R_X0, 32'd10); bus_wr(R_Y0, 32'd50); bus_wr(R_LEN, 32'd8);
        bus_wr(R_CTRL, 32'd1);
        frame_start();
        for (int xx = 0; xx <= 12; xx++) begin
            x = 11'(xx); y = 11'd50; si_rgb = 12'(xx + 12'h400);
            tick();
        end
        bus_wr(R_CTRL, 32'd2);
        park();
        bus_rd(R_STATUS, got);
        checks++;
        if (got[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL abort_status got=%b expected=%b", got[1:0], 2'b00);
        end
        // ARM together with ABORT: ABORT wins, core stays idle
        bus_wr(R_CTRL, 32'd3);
        bus_rd(R_STATUS, got);
        checks++;
        if (got[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL abort_wins got=%b expected=%b", got[1:0], 2'b00);
        end
        for (int i = 0; i < 3; i++) begin
            adr_q.push_back(14'(i)); exp_q.push_back(32'(12'h40A + i));
        end
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_ram_kept addr=%h got=%h expected=%h", a, got, exp);
            end
        end
        bus_wr(R_CTRL, 32'd1);
        frame_start();
        drive_line(50, 12'h500, 1);
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 8, 1'b0));
        adr_q.push_back(14'd0);    exp_q.push_back(32'h50A);
        adr_q.push_back(14'd7);    exp_q.push_back(32'h511);
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rearm_capture addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [31:0] got, exp;
        logic [13:0] a;
        bus_wr(R_X0, 32'd123); bus_wr(R_Y0, 32'd7); bus_wr(R_LEN, 32'd5);
        bus_wr(R_CTRL, 32'd1);
        frame_start();
        bus_rd(R_X0, got);
        checks++;
        if (got !== 32'd123) begin
            errors++;
            $display("FAIL pre_reset_x0 got=%h expected=%h", got, 32'd123);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_rd_data got=%h expected=%h", rd_data, 32'd0);
        end
        tick();
        reset_n = 1'b1;
        tick();
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b0, 0, 1'b0));
        adr_q.push_back(R_X0);     exp_q.push_back(32'd0);
        adr_q.push_back(R_Y0);     exp_q.push_back(32'd0);
        adr_q.push_back(R_LEN);    exp_q.push_back(32'd1);
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_capture addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] got, exp;
        logic [13:0] a;
        logic [11:0] pix [3];
        logic [11:0] exp12;
        bus_wr(R_X0, 32'd10); bus_wr(R_Y0, 32'd5); bus_wr(R_LEN, 32'd3);
        bus_wr(R_CTRL, 32'd5);
        frame_start();
        for (int xx = 0; xx <= 20; xx++) begin
            x = 11'(xx); y = 11'd5; si_rgb = 12'($urandom_range(0, 4095));
            if (xx >= 10 && xx <= 12) pix[xx - 10] = si_rgb;
            #1;
`ifdef CAPTURE_MARKER_EN
            exp12 = (xx >= 10 && xx <= 12) ? 12'hF0F : si_rgb;
`else
            exp12 = si_rgb;
`endif
            checks++;
            if (so_rgb !== exp12) begin
                errors++;
                $display("FAIL stream_out x=%0d got=%h expected=%h", xx, so_rgb, exp12);
            end
            tick();
        end
        // capture finished: inside the span the stream is untouched again
        x = 11'd11; y = 11'd5; si_rgb = 12'h123;
        #1;
        checks++;
        if (so_rgb !== 12'h123) begin
            errors++;
            $display("FAIL stream_after_done got=%h expected=%h", so_rgb, 12'h123);
        end
        park();
        adr_q.push_back(R_STATUS); exp_q.push_back(st(1'b0, 1'b1, 3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            adr_q.push_back(14'(i)); exp_q.push_back(32'(pix[i]));
        end
        while (exp_q.size() > 0) begin
            a = adr_q.pop_front(); bus_rd(a, got); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stream_capture addr=%h got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = 14'd0; wr_data = 32'd0;
        park();
        repeat (2) tick();
        test_reset();
        test_regs();
        test_capture_basic();
        test_boundary();
        test_mid_frame_arm();
        test_abort();
        test_reset_mid_capture();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
